// File: rtl/float_mult_pkg.sv
// float_mult_pkg: operand classes and width-generic constant builders shared by float_multiplier_pipe
package float_mult_pkg;
  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp_class_t;
  function automatic int f_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] f_inf(input int ew, input int mw);
    return ((64'd1 << ew) - 64'd1) << mw;
  endfunction
  function automatic logic [63:0] f_qnan(input int ew, input int mw);
    return ((64'd1 << (ew + 1)) - 64'd1) << (mw - 1);
  endfunction
endpackage

// File: rtl/float_mult_round.sv
// float_mult_round: combinational normalise, round-to-nearest-even and pack with status flags.
// The leading-zero count exists only when FLOAT_MULT_SUBNORMAL_EN is defined.
module float_mult_round
  import float_mult_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           i_sign,
  input  fp_class_t                      i_cls,
  input  logic [EXP_WIDTH+1:0]           i_exp,
  input  logic [2*MAN_WIDTH+1:0]         i_prod,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   o_res,
  output logic [3:0]                     o_flags
);
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int EX = EXP_WIDTH + 2;
  localparam int PW = 2 * MAN_WIDTH + 2;
  localparam int LZW = $clog2(PW) + 1;
  localparam logic [W-1:0] INF_W = W'(f_inf(EXP_WIDTH, MAN_WIDTH));
  localparam logic [W-1:0] QNAN_W = W'(f_qnan(EXP_WIDTH, MAN_WIDTH));
  localparam logic [EX-1:0] EMAX = EX'((1 << EXP_WIDTH) - 1);
  logic [LZW-1:0] w_lz;
  logic [PW-2:0] w_m;
  logic [EX-1:0] w_er;
  logic [MAN_WIDTH-1:0] w_fr;
  logic w_g, w_s, w_up, w_c, w_ovf, w_unf, w_fin;
`ifdef FLOAT_MULT_SUBNORMAL_EN
  always_comb begin
    w_lz = '0;
    for (int k = 0; k < PW; k++) if (i_prod[k]) w_lz = LZW'(PW - 1 - k);
  end
`else
  assign w_lz = LZW'(!i_prod[PW-1]);
`endif
  // After the shift the leading one sits at bit PW-1 and is dropped from w_m.
  always_comb begin
    w_m = (PW-1)'(i_prod << w_lz);
    w_g = w_m[MAN_WIDTH];
    w_s = |w_m[MAN_WIDTH-1:0];
    w_up = w_g & (w_s | w_m[MAN_WIDTH+1]);
    {w_c, w_fr} = {1'b0, w_m[PW-2:MAN_WIDTH+1]} + (MAN_WIDTH+1)'(w_up);
    w_er = i_exp + EX'(1) - EX'(w_lz) + EX'(w_c);
    w_ovf = !w_er[EX-1] && w_er >= EMAX;
    w_unf = w_er[EX-1] || w_er == '0;
    w_fin = i_cls == NORMAL;
    o_res = i_cls == NAN ? QNAN_W :
            i_cls == INF ? {i_sign, INF_W[W-2:0]} :
            i_cls == ZERO ? {i_sign, {(W-1){1'b0}}} :
            w_ovf ? {i_sign, INF_W[W-2:0]} :
            w_unf ? {i_sign, {(W-1){1'b0}}} :
            {i_sign, w_er[EXP_WIDTH-1:0], w_fr};
    o_flags = {i_cls == NAN, w_fin && w_ovf, w_fin && w_unf, w_fin && (w_ovf || w_unf || w_g || w_s)};
  end
endmodule

// File: rtl/float_multiplier_pipe.sv
// float_multiplier_pipe: 3-stage IEEE-754 multiplier (classify, multiply, round) with valid/ready on both sides.
// FLOAT_MULT_SUBNORMAL_EN: accept subnormal inputs; otherwise exp==0 operands are treated as zero.
module float_multiplier_pipe
  import float_mult_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] data_in_0,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] data_in_1,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] data_out,
  output logic [3:0]                   data_out_flags,
  output logic                         data_out_valid,
  input  logic                         data_out_ready
);
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int EX = EXP_WIDTH + 2;
  localparam int PW = 2 * MAN_WIDTH + 2;
  localparam int BIAS = f_bias(EXP_WIDTH);
`ifdef FLOAT_MULT_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  typedef struct packed {
    logic sign;
    fp_class_t cls;
    logic [EX-1:0] exp;
    logic [MAN_WIDTH:0] ma;
    logic [MAN_WIDTH:0] mb;
  } s1_t;
  typedef struct packed {
    logic sign;
    fp_class_t cls;
    logic [EX-1:0] exp;
    logic [PW-1:0] prod;
  } s2_t;
  function automatic fp_class_t f_cls(input logic [W-1:0] x);
    return &x[W-2:MAN_WIDTH] ? (|x[MAN_WIDTH-1:0] ? NAN : INF) :
           |x[W-2:MAN_WIDTH] ? NORMAL :
           (SUB_EN && |x[MAN_WIDTH-1:0]) ? SUBNORM : ZERO;
  endfunction
  function automatic logic [EX-1:0] f_exp(input logic [W-1:0] x, input fp_class_t c);
    return c == SUBNORM ? EX'(1) : EX'(x[W-2:MAN_WIDTH]);
  endfunction
  fp_class_t w_ca, w_cb;
  s1_t w_s1, r_s1;
  s2_t r_s2;
  logic r_v1, r_v2, r_ov, w_en;
  logic [W-1:0] r_out, w_res;
  logic [3:0] r_flags, w_flags;
  assign w_ca = f_cls(data_in_0);
  assign w_cb = f_cls(data_in_1);
  // Result class is settled in S1 so later stages only carry a tag; NORMAL means "compute".
  always_comb begin
    w_s1.sign = data_in_0[W-1] ^ data_in_1[W-1];
    w_s1.cls = (w_ca == NAN || w_cb == NAN || (w_ca == ZERO && w_cb == INF) || (w_ca == INF && w_cb == ZERO)) ? NAN :
               (w_ca == INF || w_cb == INF) ? INF :
               (w_ca == ZERO || w_cb == ZERO) ? ZERO : NORMAL;
    w_s1.exp = f_exp(data_in_0, w_ca) + f_exp(data_in_1, w_cb) - EX'(BIAS);
    w_s1.ma = {w_ca == NORMAL, data_in_0[MAN_WIDTH-1:0]};
    w_s1.mb = {w_cb == NORMAL, data_in_1[MAN_WIDTH-1:0]};
  end
  assign w_en = !r_ov || data_out_ready;
  float_mult_round #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_round (
    .i_sign(r_s2.sign),
    .i_cls(r_s2.cls),
    .i_exp(r_s2.exp),
    .i_prod(r_s2.prod),
    .o_res(w_res),
    .o_flags(w_flags)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_ov <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_out <= '0;
      r_flags <= '0;
    end else if (w_en) begin
      r_v1 <= data_in_valid;
      r_s1 <= w_s1;
      r_v2 <= r_v1;
      r_s2 <= '{sign: r_s1.sign, cls: r_s1.cls, exp: r_s1.exp, prod: PW'(r_s1.ma) * PW'(r_s1.mb)};
      r_ov <= r_v2;
      r_out <= w_res;
      r_flags <= w_flags;
    end
  assign data_in_ready = w_en;
  assign data_out = r_out;
  assign data_out_flags = r_flags;
  assign data_out_valid = r_ov;
endmodule
